ps2_tx: RTL and testbench

- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED LED-set, 0xFF reset, 0xF4 enable.
- Companion to the existing PS/2 receiver and acquisition machine on the same ps2c/ps2d pair.
- Drives the lines open-drain through output enables; top level builds the tri-states.
- tx_idle_o gates the receiver's rx_en so the receiver ignores the host's own frame.

---
 rtl/ps2_pkg.sv | 23 ++
 rtl/ps2_clk_filter.sv | 44 ++++
 rtl/ps2_tx.sv | 140 ++++++++++++++
 tb/tb_ps2_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared types, constants and parity helper for the PS/2 blocks
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RTS      = 3'd1,
      START    = 3'd2,
      DATA     = 3'd3,
      STOP     = 3'd4,
      ACK      = 3'd5,
      WAIT_REL = 3'd6
   } state_t;

   localparam int FRAME_LEN          = 9;
   localparam int DEF_INHIBIT_CYCLES = 10000;
   localparam int DEF_TIMEOUT_CYCLES = 2000000;
   localparam int DEF_FILTER_LEN     = 8;

   function automatic logic odd_parity(input logic [7:0] d);
      return ~^d;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// rtl/ps2_clk_filter.sv - ps2c/ps2d synchronisers, ps2c glitch filter and fall pulse
module ps2_clk_filter
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN = DEF_FILTER_LEN
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ps2c,
   input  logic ps2d,
   output logic clk_filt,
   output logic data_sync,
   output logic fall
);

   logic [1:0]            c_sync;
   logic [1:0]            d_sync;
   logic [FILTER_LEN-1:0] shift;

   // Idle PS/2 lines float high, so everything resets to the released level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_sync   <= 2'b11;
         d_sync   <= 2'b11;
         shift    <= '1;
         clk_filt <= 1'b1;
         fall     <= 1'b0;
      end else begin
         c_sync <= {c_sync[0], ps2c};
         d_sync <= {d_sync[0], ps2d};
         shift  <= {shift[FILTER_LEN-2:0], c_sync[1]};
         fall   <= 1'b0;
         if (shift == '1) begin
            clk_filt <= 1'b1;
         end else if (shift == '0) begin
            clk_filt <= 1'b0;
            fall     <= clk_filt;
         end
      end
   end

   assign data_sync = d_sync[1];

endmodule

// File: rtl/ps2_tx.sv
// rtl/ps2_tx.sv - host-to-device PS/2 command transmitter with open-drain enables
module ps2_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int FILTER_LEN     = DEF_FILTER_LEN
) (
   input  logic       Clock_i,
   input  logic       Reset_i,
   input  logic       wr_ps2_i,
   input  logic [7:0] din_i,
   input  logic       ps2c_i,
   input  logic       ps2d_i,
   output logic       ps2c_oe_o,
   output logic       ps2d_oe_o,
   output logic       tx_idle_o,
   output logic       tx_done_tick_o,
   output logic       tx_err_tick_o
);

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);

   state_t                 state, state_next;
   logic [CNT_W-1:0]       cnt, cnt_next;
   logic [3:0]             n, n_next;
   logic [FRAME_LEN-1:0]   frame, frame_next;
   logic                   ack_bit, ack_next;
   logic                   done_next, err_next;
   logic                   clk_filt, data_sync, fall;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
      .clk       (Clock_i),
      .rst_n     (Reset_i),
      .ps2c      (ps2c_i),
      .ps2d      (ps2d_i),
      .clk_filt  (clk_filt),
      .data_sync (data_sync),
      .fall      (fall)
   );

   always_ff @(posedge Clock_i or negedge Reset_i) begin
      if (!Reset_i) begin
         state          <= IDLE;
         cnt            <= '0;
         n              <= '0;
         frame          <= '0;
         ack_bit        <= 1'b1;
         tx_done_tick_o <= 1'b0;
         tx_err_tick_o  <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         n              <= n_next;
         frame          <= frame_next;
         ack_bit        <= ack_next;
         tx_done_tick_o <= done_next;
         tx_err_tick_o  <= err_next;
      end
   end

   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      n_next     = n;
      frame_next = frame;
      ack_next   = ack_bit;
      done_next  = 1'b0;
      err_next   = 1'b0;
      case (state)
         IDLE: begin
            if (wr_ps2_i) begin
               frame_next = {odd_parity(din_i), din_i};
               cnt_next   = CNT_W'(INHIBIT_CYCLES - 1);
               state_next = RTS;
            end
         end
         RTS: begin
            if (cnt == '0) begin
               cnt_next   = CNT_W'(TIMEOUT_CYCLES - 1);
               n_next     = '0;
               state_next = START;
            end else begin
               cnt_next = cnt - 1'b1;
            end
         end
         default: begin
            // Timeout is checked ahead of any clock edge so it always wins.
            if (cnt == '0) begin
               err_next   = 1'b1;
               state_next = IDLE;
            end else begin
               cnt_next = cnt - 1'b1;
               case (state)
                  START: begin
                     if (fall) begin
                        n_next     = '0;
                        state_next = DATA;
                     end
                  end
                  DATA: begin
                     if (fall) begin
                        if (n == 4'(FRAME_LEN - 1)) state_next = STOP;
                        else                        n_next     = n + 4'd1;
                     end
                  end
                  STOP: begin
                     // The device drives its acknowledge onto the stop-bit fall.
                     if (fall) begin
                        ack_next   = data_sync;
                        state_next = ACK;
                     end
                  end
                  ACK: begin
                     if (!ack_bit) begin
                        state_next = WAIT_REL;
                     end else begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                     end
                  end
                  WAIT_REL: begin
                     if (clk_filt && data_sync) begin
                        done_next  = 1'b1;
                        state_next = IDLE;
                     end
                  end
                  default: state_next = IDLE;
               endcase
            end
         end
      endcase
   end

   assign ps2c_oe_o = (state == RTS);
   assign ps2d_oe_o = (state == START) || ((state == DATA) && !frame[n]);
   assign tx_idle_o = (state == IDLE);

endmodule

// File: tb/tb_ps2_tx.sv
// tb/tb_ps2_tx.sv - self-checking bench for ps2_tx with a PS/2 device model
module tb_ps2_tx;

   localparam int INHIBIT = 20;
   localparam int TIMEOUT = 5000;
   localparam int HALF    = 20;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       wr;
   logic [7:0] din;
   logic       bfm_c, bfm_d;
   logic       ps2c_line, ps2d_line;
   logic       ps2c_oe, ps2d_oe, tx_idle, done_tick, err_tick;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int bad_idle = 0;

   assign ps2c_line = bfm_c & ~ps2c_oe;
   assign ps2d_line = bfm_d & ~ps2d_oe;

   always #5 clk = ~clk;

   ps2_tx #(.INHIBIT_CYCLES(INHIBIT), .TIMEOUT_CYCLES(TIMEOUT), .FILTER_LEN(4)) dut (
      .Clock_i        (clk),
      .Reset_i        (rst_n),
      .wr_ps2_i       (wr),
      .din_i          (din),
      .ps2c_i         (ps2c_line),
      .ps2d_i         (ps2d_line),
      .ps2c_oe_o      (ps2c_oe),
      .ps2d_oe_o      (ps2d_oe),
      .tx_idle_o      (tx_idle),
      .tx_done_tick_o (done_tick),
      .tx_err_tick_o  (err_tick)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (done_tick) done_cnt++;
         if (err_tick) err_cnt++;
         if (done_tick && err_tick) both_cnt++;
         if ((done_tick || err_tick) && !tx_idle) bad_idle++;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   task automatic wait_cycles(input int k);
      repeat (k) @(negedge clk);
   endtask

   // Reference frame: start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int ones;
      ones = 0;
      f[0] = 1'b0;
      for (int i = 0; i < 8; i++) begin
         f[i+1] = d[i];
         ones += d[i];
      end
      f[9]  = (ones % 2 == 0) ? 1'b1 : 1'b0;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_frame(input logic [7:0] d, input bit ack, input int wr_at,
                             input int abort_at, output logic [10:0] bits, output int inh);
      int t;
      bits = '1;
      inh  = 0;
      din  = d;
      wr   = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      t = 0;
      while (!ps2c_oe && t < 100) begin
         @(negedge clk);
         t++;
      end
      while (ps2c_oe && inh < 1000) begin
         inh++;
         @(negedge clk);
      end
      wait_cycles(10);
      bits[0] = ps2d_line;
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) bfm_d = ~ack;
         bfm_c = 1'b0;
         wait_cycles(HALF / 2);
         if (k == wr_at) begin
            din = ~d;
            wr  = 1'b1;
            @(negedge clk);
            wr = 1'b0;
            wait_cycles(HALF / 2 - 1);
         end else if (k == abort_at) begin
            check("pre_reset_ps2d_oe", int'(ps2d_oe), 1);
            #2 rst_n = 1'b0;
            #1;
            check("reset_ps2c_oe", int'(ps2c_oe), 0);
            check("reset_ps2d_oe", int'(ps2d_oe), 0);
            check("reset_tx_idle", int'(tx_idle), 1);
            bfm_c = 1'b1;
            bfm_d = 1'b1;
            @(negedge clk);
            return;
         end else begin
            wait_cycles(HALF / 2);
         end
         bfm_c = 1'b1;
         wait_cycles(HALF / 2);
         if (k <= 10) bits[k] = ps2d_line;
         wait_cycles(HALF / 2);
      end
      bfm_d = 1'b1;
   endtask

   task automatic wait_tick(input string name);
      int t;
      t = 0;
      while (done_cnt + err_cnt == 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      if (t >= 400) check({name, "_tick_timeout"}, 1, 0);
      wait_cycles(2);
   endtask

   typedef struct {
      logic [7:0] d;
      bit         ack;
      int         exp_parity;
      int         exp_done;
      int         exp_err;
   } vec_t;

   vec_t        vecs[5];
   logic [10:0] bits;
   logic [10:0] exp_bits;
   int          inh;
   int          cyc;
   int          rts_seen;
   logic [7:0]  rd;
   bit          rack;

   initial begin
      vecs[0] = '{8'hED, 1'b1, 1, 1, 0};
      vecs[1] = '{8'h00, 1'b1, 1, 1, 0};
      vecs[2] = '{8'hFF, 1'b1, 1, 1, 0};
      vecs[3] = '{8'h01, 1'b1, 0, 1, 0};
      vecs[4] = '{8'hF4, 1'b0, 0, 0, 1};

      rst_n = 1'b0;
      wr    = 1'b0;
      din   = 8'h00;
      bfm_c = 1'b1;
      bfm_d = 1'b1;
      wait_cycles(5);
      check("rst_ps2c_oe", int'(ps2c_oe), 0);
      check("rst_ps2d_oe", int'(ps2d_oe), 0);
      check("rst_tx_idle", int'(tx_idle), 1);
      check("rst_done", int'(done_tick), 0);
      check("rst_err", int'(err_tick), 0);
      rst_n = 1'b1;
      wait_cycles(10);

      foreach (vecs[i]) begin
         done_cnt = 0;
         err_cnt  = 0;
         send_frame(vecs[i].d, vecs[i].ack, -1, -1, bits, inh);
         wait_tick("vec");
         check("vec_inhibit", inh, INHIBIT);
         check("vec_start", int'(bits[0]), 0);
         check("vec_data", int'(bits[8:1]), int'(vecs[i].d));
         check("vec_parity", int'(bits[9]), vecs[i].exp_parity);
         check("vec_stop", int'(bits[10]), 1);
         check("vec_done", done_cnt, vecs[i].exp_done);
         check("vec_err", err_cnt, vecs[i].exp_err);
         check("vec_idle", int'(tx_idle), 1);
         check("vec_lines", int'({ps2c_oe, ps2d_oe}), 0);
         wait_cycles(30);
      end

      for (int r = 0; r < 6; r++) begin
         rd   = 8'($urandom);
         rack = ($urandom_range(0, 3) != 0);
         done_cnt = 0;
         err_cnt  = 0;
         send_frame(rd, rack, -1, -1, bits, inh);
         wait_tick("rnd");
         exp_bits = model_frame(rd);
         check("rnd_frame", int'(bits), int'(exp_bits));
         check("rnd_done", done_cnt, rack ? 1 : 0);
         check("rnd_err", err_cnt, rack ? 0 : 1);
         wait_cycles(30);
      end

      done_cnt = 0;
      err_cnt  = 0;
      send_frame(8'hA5, 1'b1, 4, -1, bits, inh);
      wait_tick("busy");
      check("busy_frame", int'(bits), int'(model_frame(8'hA5)));
      check("busy_done", done_cnt, 1);
      rts_seen = 0;
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         if (ps2c_oe) rts_seen++;
      end
      check("busy_no_second_frame", rts_seen, 0);

      done_cnt = 0;
      err_cnt  = 0;
      send_frame(8'h00, 1'b1, -1, 3, bits, inh);
      wait_cycles(5);
      rst_n = 1'b1;
      wait_cycles(20);
      check("abort_no_tick", done_cnt + err_cnt, 0);
      send_frame(8'h3C, 1'b1, -1, -1, bits, inh);
      wait_tick("fresh");
      check("fresh_inhibit", inh, INHIBIT);
      check("fresh_frame", int'(bits), int'(model_frame(8'h3C)));
      check("fresh_done", done_cnt, 1);
      wait_cycles(30);

      done_cnt = 0;
      err_cnt  = 0;
      din = 8'hFF;
      wr  = 1'b1;
      @(negedge clk);
      wr = 1'b0;
      cyc = 0;
      while (!ps2c_oe && cyc < 100) begin
         @(negedge clk);
         cyc++;
      end
      cyc = 0;
      while (ps2c_oe && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      cyc = 0;
      while (!err_tick && cyc < TIMEOUT + 500) begin
         @(negedge clk);
         cyc++;
      end
      check("timeout_cycles", cyc, TIMEOUT);
      check("timeout_lines", int'({ps2c_oe, ps2d_oe}), 0);
      check("timeout_idle", int'(tx_idle), 1);
      wait_cycles(5);
      check("timeout_err", err_cnt, 1);
      check("timeout_done", done_cnt, 0);

      check("ticks_exclusive", both_cnt, 0);
      check("idle_with_tick", bad_idle, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
